dmem_stream_reader: RTL

- Read-side DMA engine for the byte-wide data memory (19-bit address, 8-bit data).
- After the processor has written a result buffer (for example RSA-decrypted image bytes), this block streams a contiguous region out, oldest byte first, on a valid/ready byte stream.
- The downstream consumer is the display or pixel path.
- The block shares the RAM with the processor through a request/grant pair and absorbs the RAM's 1-cycle read latency in a small FIFO.

---
 rtl/dmem_stream_reader_pkg.sv | 19 +
 rtl/dmem_stream_reader_if.sv | 27 ++
 rtl/dmem_stream_reader_sync_fifo.sv | 61 ++++++
 rtl/dmem_stream_reader.sv | 123 ++++++++++++
 4 files changed

// File: rtl/dmem_stream_reader_pkg.sv
// Shared types for the data-memory read path: address/byte typedefs and the reader FSM states.
// Latency: none, this file holds declarations only.
// Backpressure: not applicable.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 19;
    localparam int DMEM_DATA_W = 8;

    typedef logic [DMEM_ADDR_W-1:0] dmem_addr_t;
    typedef logic [DMEM_DATA_W-1:0] dmem_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        FINISH
    } rd_state_t;

endpackage

// File: rtl/dmem_stream_reader_if.sv
// RAM read port (req/gnt, address, q) plus the outgoing valid/ready byte stream.
// Latency: wires only; the RAM's q follows the sampled address by one cycle.
// Backpressure: out_ready from the consumer, mem_gnt from the RAM arbiter.
// Ports: master = reader side (drives mem_req/mem_addr/out_*), slave = RAM arbiter + consumer.
interface dmem_stream_reader_if #(
    parameter int ADDR_W = dmem_pkg::DMEM_ADDR_W,
    parameter int DATA_W = dmem_pkg::DMEM_DATA_W
);
    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output mem_req, mem_addr, out_data, out_valid, out_last,
        input  mem_gnt, mem_rdata, out_ready
    );

    modport slave (
        input  mem_req, mem_addr, out_data, out_valid, out_last,
        output mem_gnt, mem_rdata, out_ready
    );
endinterface

// File: rtl/dmem_stream_reader_sync_fifo.sv
// Generic synchronous FIFO with occupancy count and full/empty flags.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
// Ports: clk/rst (sync active-low), push/push_dat, pop/pop_dat (head), count, full, empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    // Storage needs no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/dmem_stream_reader.sv
// Read-side DMA: streams length bytes from base_addr out of the shared data RAM, oldest first.
// Latency: first out_valid two cycles after the edge that samples start; then 1 byte/cycle.
// Backpressure: reads stop when FIFO occupancy plus the in-flight read reaches FIFO_DEPTH; mem_gnt low stalls issue only.
// Ports: clk, rst (sync active-low), start/base_addr/length control, busy/done status, bus = RAM port + byte stream.
module dmem_stream_reader
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    dmem_stream_reader_if.master bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    rd_state_t         state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] remain;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] sent_cnt;
    logic              inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    logic              fifo_full;
    logic              fifo_empty;
    logic              issue;
    logic              pop;

    // A read slot is only taken if its returning byte is guaranteed a FIFO entry,
    // counting the read already on its way back.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    assign issue = (state == FETCH) && bus.mem_gnt && (remain != '0) && !fifo_full
                   && (credit_used < (CNT_W+1)'(FIFO_DEPTH));

    // FETCH is left on the issue that empties remain, so mem_req can follow the state.
    assign bus.mem_req   = (state == FETCH);
    assign bus.mem_addr  = cur_addr;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_last  = !fifo_empty && (sent_cnt == len_q - ADDR_W'(1));
    assign pop           = bus.out_valid && bus.out_ready;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_dat (bus.mem_rdata),
        .pop      (pop),
        .pop_dat  (bus.out_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cur_addr <= '0;
            remain   <= '0;
            len_q    <= '0;
            sent_cnt <= '0;
            inflight <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // The RAM returns q one cycle after an issued address: push then.
            inflight <= issue;
            done     <= 1'b0;
            if (pop) begin
                sent_cnt <= sent_cnt + ADDR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr <= base_addr;
                        remain   <= length;
                        len_q    <= length;
                        sent_cnt <= '0;
                        if (length == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                            busy  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (issue) begin
                        cur_addr <= cur_addr + ADDR_W'(1);
                        remain   <= remain - ADDR_W'(1);
                        if (remain == ADDR_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && bus.out_last) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
